// File: rtl/plic_lite_pkg.sv
// plic_lite_pkg: shared definitions for the plic_lite interrupt aggregator.
//   - Word addresses of the MMIO register file.
//   - Encodings of the eip hand-off state machine.
//   - prio_addr(): word address of the priority register for a source index.
package plic_lite_pkg;

  localparam logic [3:0] ADDR_PEND      = 4'h0;
  localparam logic [3:0] ADDR_EN        = 4'h1;
  localparam logic [3:0] ADDR_THR       = 4'h2;
  localparam logic [3:0] ADDR_CLAIM     = 4'h3;
  localparam logic [3:0] ADDR_PRIO_BASE = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  function automatic logic [3:0] prio_addr(input int unsigned idx);
    return ADDR_PRIO_BASE + 4'(idx);
  endfunction

endpackage

// File: rtl/plic_arbiter.sv
// plic_arbiter: combinational search for the best eligible interrupt source.
//   pending, enable : per-source state, bit i is source ID i+1
//   threshold       : a source must have priority strictly above this
//   prio            : per-source priority
//   id              : winning source ID (highest priority, lowest index on
//                     ties), 0 when nothing is eligible
module plic_arbiter
  import plic_lite_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int PRIW = 3,
  parameter int IDW  = $clog2(NSRC + 1)
) (
  input  logic [NSRC-1:0]           pending,
  input  logic [NSRC-1:0]           enable,
  input  logic [PRIW-1:0]           threshold,
  input  logic [NSRC-1:0][PRIW-1:0] prio,
  output logic [IDW-1:0]            id
);

  logic [PRIW-1:0] best_prio;

  // NOTE: every variable written here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred; blocking '=' is right
  // in combinational logic because later iterations must see earlier updates.
  always_comb begin
    best_prio = '0;
    id        = '0;
    // Strict '>' keeps the first (lowest-index) source on equal priority.
    // Priority 0 can never beat threshold >= 0, so it never interrupts.
    for (int i = 0; i < NSRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > threshold) &&
          (prio[i] > best_prio)) begin
        best_prio = prio[i];
        id        = IDW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/plic_lite.sv
// plic_lite: external-interrupt aggregator feeding the privilege unit.
//   clk, rst   : clock, synchronous active-high reset
//   a, d       : word address and write data of the MMIO register file
//   we, re     : write strobe, read strobe (re qualifies the claim)
//   spo        : combinational read data for address a
//   irq        : device interrupt pulses, bit i is source ID i+1
//   eip        : external interrupt pending, held until eip_reply
//   eip_reply  : one-cycle acknowledge from the privilege unit
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int PRIW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            re,
  output logic [31:0]     spo,
  input  logic [NSRC-1:0] irq,
  output logic            eip,
  input  logic            eip_reply
);

  localparam int IDW = $clog2(NSRC + 1);

  logic [NSRC-1:0]           irq_prev;
  logic [NSRC-1:0]           pending;
  logic [NSRC-1:0]           enable;
  logic [PRIW-1:0]           threshold;
  logic [NSRC-1:0][PRIW-1:0] prio;
  logic [IDW-1:0]            best_id;
  logic [IDW-1:0]            claimed_id;
  logic [IDW-1:0]            arb_id;
  state_e                    state, state_next;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] claim_mask;
  logic            claim_hit;
  logic            complete_hit;
  logic            unused_bits;

  assign unused_bits = ^d[31:8];

  plic_arbiter #(.NSRC(NSRC), .PRIW(PRIW), .IDW(IDW)) u_arbiter (
    .pending   (pending),
    .enable    (enable),
    .threshold (threshold),
    .prio      (prio),
    .id        (arb_id)
  );

  assign rise         = irq & ~irq_prev;
  assign claim_hit    = re && (a == ADDR_CLAIM) && (best_id != '0);
  assign complete_hit = we && (a == ADDR_CLAIM) && (claimed_id != '0) &&
                        (d[7:0] == 8'(claimed_id));

  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_mask[i] = claim_hit && (best_id == IDW'(i + 1));
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of the others. The priority table is a handful of control
  // flops rather than a RAM, so it is reset along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev   <= '0;
      pending    <= '0;
      enable     <= '0;
      threshold  <= '0;
      prio       <= '0;
      best_id    <= '0;
      claimed_id <= '0;
      state      <= ST_IDLE;
    end else begin
      irq_prev <= irq;
      // A new edge is OR-ed in after the claim clear, so set wins a collision.
      pending  <= (pending & ~claim_mask) | rise;
      // Arbitration result is one cycle behind the register state it reads.
      best_id  <= arb_id;
      state    <= state_next;

      if (claim_hit)         claimed_id <= best_id;
      else if (complete_hit) claimed_id <= '0;

      if (we && (a == ADDR_EN))  enable    <= d[NSRC-1:0];
      if (we && (a == ADDR_THR)) threshold <= d[PRIW-1:0];
      for (int i = 0; i < NSRC; i++) begin
        if (we && (a == prio_addr(i))) prio[i] <= d[PRIW-1:0];
      end
    end
  end

  // eip hand-off: once raised, eip is a level held until the privilege unit
  // replies, regardless of later changes in eligibility.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (best_id != '0) state_next = ST_ASSERT;
      ST_ASSERT:  if (eip_reply)     state_next = ST_SERVICE;
      ST_SERVICE: if (complete_hit)  state_next = ST_DRAIN;
      // One settling cycle so a just-completed source is not re-signalled
      // from a stale best_id.
      ST_DRAIN:                      state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  assign eip = (state == ST_ASSERT);

  always_comb begin
    spo = '0;
    case (a)
      ADDR_PEND:  spo[NSRC-1:0] = pending;
      ADDR_EN:    spo[NSRC-1:0] = enable;
      ADDR_THR:   spo[PRIW-1:0] = threshold;
      ADDR_CLAIM: spo[IDW-1:0]  = best_id;
      default: begin
        for (int i = 0; i < NSRC; i++) begin
          if (a == prio_addr(i)) spo[PRIW-1:0] = prio[i];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_plic_lite.sv
// tb_plic_lite: directed self-checking bench for plic_lite (NSRC=4, PRIW=3).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_plic_lite;
  import plic_lite_pkg::*;

  localparam int NSRC = 4;
  localparam int PRIW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      a;
  logic [31:0]     d;
  logic            we;
  logic            re;
  logic [31:0]     spo;
  logic [NSRC-1:0] irq;
  logic            eip;
  logic            eip_reply;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  plic_lite #(.NSRC(NSRC), .PRIW(PRIW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .d         (d),
    .we        (we),
    .re        (re),
    .spo       (spo),
    .irq       (irq),
    .eip       (eip),
    .eip_reply (eip_reply)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] v);
    a = addr;
    #1 v = spo;
    @(negedge clk);
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] addr,
                        input logic [31:0] exp);
    logic [31:0] v;
    rd(addr, v);
    check(tag, v, exp);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    a  = addr;
    d  = data;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic claim(output logic [31:0] v);
    a  = ADDR_CLAIM;
    re = 1'b1;
    #1 v = spo;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic reply();
    eip_reply = 1'b1;
    @(negedge clk);
    eip_reply = 1'b0;
  endtask

  task automatic pulse(input logic [NSRC-1:0] mask);
    irq = mask;
    @(negedge clk);
    irq = '0;
  endtask

  // Bounded wait for eip; n is the number of cycles waited.
  task automatic wait_eip(input int max, output int n);
    n = 0;
    while (eip !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_eip(input string tag, input int max);
    int n;
    wait_eip(max, n);
    check(tag, 32'(eip), 32'd1);
  endtask

  // eip must stay low for ncyc cycles.
  task automatic hold_low(input string tag, input int ncyc);
    int hi = 0;
    repeat (ncyc) begin
      if (eip !== 1'b0) hi++;
      @(negedge clk);
    end
    check(tag, 32'(hi), 32'd0);
  endtask

  // Full handler round trip: wait for eip, reply, claim, complete.
  task automatic service(input string tag, input int id);
    logic [31:0] v;
    expect_eip({tag, "_eip"}, 6);
    reply();
    check({tag, "_eip_drop"}, 32'(eip), 32'd0);
    claim(v);
    check({tag, "_claim"}, v, 32'(id));
    wr(ADDR_CLAIM, 32'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          n;
    int          lo;

    rst = 1'b1; a = '0; d = '0; we = 1'b0; re = 1'b0;
    irq = '0; eip_reply = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and register map boundaries
    check("rst_eip", 32'(eip), 32'd0);
    chk_rd("rst_pend", ADDR_PEND, 32'h0);
    chk_rd("rst_en", ADDR_EN, 32'h0);
    chk_rd("rst_thr", ADDR_THR, 32'h0);
    chk_rd("rst_prio0", prio_addr(0), 32'h0);
    chk_rd("rst_claim_peek", ADDR_CLAIM, 32'h0);
    wr(4'hF, 32'hFFFF_FFFF);
    chk_rd("unmapped_f", 4'hF, 32'h0);
    wr(4'h8, 32'hFFFF_FFFF);
    chk_rd("unmapped_8", 4'h8, 32'h0);
    wr(ADDR_PEND, 32'hFFFF_FFFF);
    chk_rd("pend_readonly", ADDR_PEND, 32'h0);

    // 1. Single source
    wr(ADDR_EN, 32'hFFFF_FFF1);
    chk_rd("t1_en_mask", ADDR_EN, 32'h1);
    wr(prio_addr(0), 32'hFFFF_FFF9);
    chk_rd("t1_prio_mask", prio_addr(0), 32'h1);
    wr(ADDR_THR, 32'h0);
    pulse(4'b0001);
    wait_eip(3, n);
    check("t1_eip_rise", 32'(eip), 32'd1);
    lo = 0;
    repeat (10) begin
      @(negedge clk);
      if (eip !== 1'b1) lo++;
    end
    check("t1_eip_hold", 32'(lo), 32'd0);
    reply();
    check("t1_eip_drop", 32'(eip), 32'd0);
    claim(v);
    check("t1_claim", v, 32'd1);
    chk_rd("t1_pend_clr", ADDR_PEND, 32'h0);
    wr(ADDR_CLAIM, 32'd1);
    hold_low("t1_quiet", 5);

    // 2. Priority and tie
    wr(ADDR_EN, 32'hF);
    wr(prio_addr(1), 32'd5);
    wr(prio_addr(2), 32'd5);
    wr(prio_addr(3), 32'd2);
    pulse(4'b1110);
    service("t2_a", 2);
    service("t2_b", 3);
    service("t2_c", 4);
    hold_low("t2_quiet", 4);

    // 3. Threshold (and a stray reply in IDLE)
    wr(ADDR_THR, 32'd5);
    wr(prio_addr(0), 32'd5);
    pulse(4'b0001);
    reply();
    hold_low("t3_below_thr", 20);
    chk_rd("t3_pend", ADDR_PEND, 32'h1);
    wr(ADDR_THR, 32'd4);
    service("t3", 1);

    // 4. Complete guard
    pulse(4'b0010);
    expect_eip("t4_eip", 6);
    reply();
    claim(v);
    check("t4_claim", v, 32'd2);
    wr(ADDR_CLAIM, 32'd3);
    pulse(4'b0001);
    hold_low("t4_guard", 10);
    wr(ADDR_CLAIM, 32'd2);
    wait_eip(6, n);
    check("t4_reassert", 32'(eip), 32'd1);
    check("t4_latency_2to3", 32'(n >= 2 && n <= 3), 32'd1);
    reply();
    claim(v);
    check("t4_claim2", v, 32'd1);
    wr(ADDR_CLAIM, 32'd1);

    // 5a. Level held high counts once
    irq = 4'b0001;
    expect_eip("t5_level_eip", 6);
    reply();
    claim(v);
    check("t5_level_claim", v, 32'd1);
    chk_rd("t5_level_pend", ADDR_PEND, 32'h0);
    irq = '0;
    wr(ADDR_CLAIM, 32'd1);
    hold_low("t5_single_event", 5);
    chk_rd("t5_pend_after", ADDR_PEND, 32'h0);

    // 5b. Edge and claim collide: set wins
    pulse(4'b0001);
    expect_eip("t5_col_eip", 6);
    reply();
    irq = 4'b0001;
    claim(v);
    irq = '0;
    check("t5_col_claim", v, 32'd1);
    chk_rd("t5_col_pend", ADDR_PEND, 32'h1);
    wr(ADDR_CLAIM, 32'd1);
    service("t5_resignal", 1);

    // 6. Reset mid-operation
    pulse(4'b1010);
    expect_eip("t6_eip", 6);
    chk_rd("t6_pend", ADDR_PEND, 32'hA);
    check("t6_still_assert", 32'(eip), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_eip_fall", 32'(eip), 32'd0);
    rst = 1'b0;
    chk_rd("t6_pend_rst", ADDR_PEND, 32'h0);
    chk_rd("t6_en_rst", ADDR_EN, 32'h0);
    chk_rd("t6_thr_rst", ADDR_THR, 32'h0);
    for (int i = 0; i < NSRC; i++) begin
      chk_rd($sformatf("t6_prio%0d_rst", i), prio_addr(i), 32'h0);
    end
    chk_rd("t6_claim_rst", ADDR_CLAIM, 32'h0);
    hold_low("t6_quiet", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
